// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register addresses, exception codes and field positions
package cp0_pkg;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
  localparam logic [4:0] ADDR_CONFIG   = 5'd16;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int ST_IM_LO   = 8;
  localparam int ST_IM_HI   = 15;
  localparam int CA_EXC_LO  = 2;
  localparam int CA_EXC_HI  = 6;
  localparam int CA_IP_LO   = 8;
  localparam int CA_IP_HI   = 15;
  localparam int CA_HWIP_LO = 10;
  localparam int CA_BD      = 31;

  localparam logic [31:0] STATUS_WMASK = 32'hF000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;
  localparam logic [31:0] STATUS_RST   = 32'h1000_0000;
  localparam logic [31:0] CONFIG_VAL   = 32'h0000_8000;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_if.sv
// rtl/cp0_exc_if.sv - link between the CP0 register file and its Count/Compare timer
interface cp0_exc_if;
  logic        wr_count;
  logic        wr_compare;
  logic [31:0] wdata;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_int;

  modport master (output wr_count, wr_compare, wdata, input count, compare, timer_int);
  modport slave  (input wr_count, wr_compare, wdata, output count, compare, timer_int);
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare pair with prescaler and sticky timer interrupt
module cp0_timer #(
  parameter int COUNT_DIV = 1
) (
  input  logic      clk,
  input  logic      rst,
  cp0_exc_if.slave  tmr
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        div_q, div_d;
  logic        timer_q, timer_d;
  logic        tick;

  always_comb begin
    tick      = (COUNT_DIV == 1) ? 1'b1 : div_q;
    div_d     = (COUNT_DIV == 1) ? 1'b0 : ~div_q;
    count_d   = tick ? count_q + 32'd1 : count_q;
    if (tmr.wr_count) begin
      count_d = tmr.wdata;
      div_d   = 1'b0;
    end
    compare_d = tmr.wr_compare ? tmr.wdata : compare_q;
    // A Compare write acknowledges the interrupt, even in the match cycle.
    timer_d   = timer_q;
    if (tmr.wr_compare)
      timer_d = 1'b0;
    else if ((count_q == compare_q) && (compare_q != 32'd0))
      timer_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      div_q     <= 1'b0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      div_q     <= div_d;
      timer_q   <= timer_d;
    end
  end

  assign tmr.count     = count_q;
  assign tmr.compare   = compare_q;
  assign tmr.timer_int = timer_q;

endmodule

// File: rtl/cp0_exc.sv
// rtl/cp0_exc.sv - CP0 Status/Cause/EPC, exception entry/return and mfc0/mtc0 access
// Optional BadVAddr register enabled by defining CP0_BADVADDR_EN.
module cp0_exc
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 5,
  parameter int          COUNT_DIV  = 1,
  parameter logic [31:0] PRID_VAL   = 32'h0001_0101
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic                  timer_int_o,
  output logic                  int_req_o
);

  cp0_exc_if tif ();

  assign tif.wr_count   = we_i && (waddr_i == ADDR_COUNT);
  assign tif.wr_compare = we_i && (waddr_i == ADDR_COMPARE);
  assign tif.wdata      = wdata_i;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk (clk),
    .rst (rst),
    .tmr (tif.slave)
  );

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  hw_ip;
  logic [31:0] badvaddr_rd;

  always_comb begin
    hw_ip                   = '0;
    hw_ip[NUM_HW_INT-1:0]   = int_i;
  end

  // Exception entry beats eret, which beats a software write to the same registers.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (exc_valid_i) begin
      if (!status_q[ST_EXL]) begin
        epc_d          = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
        cause_d[CA_BD] = exc_bd_i;
      end
      cause_d[CA_EXC_HI:CA_EXC_LO] = exc_code_i;
      status_d[ST_EXL]             = 1'b1;
    end else if (eret_i) begin
      status_d[ST_EXL] = 1'b0;
    end else if (we_i) begin
      case (waddr_i)
        ADDR_STATUS: status_d = wdata_i & STATUS_WMASK;
        ADDR_CAUSE:  cause_d  = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
        ADDR_EPC:    epc_d    = wdata_i;
        default:     ;
      endcase
    end
    cause_d[CA_IP_HI:CA_HWIP_LO] = {tif.timer_int, hw_ip};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;

  always_comb begin
    badvaddr_d = badvaddr_q;
    if (exc_valid_i && is_addr_exc(exc_code_i))
      badvaddr_d = exc_badvaddr_i;
  end

  always_ff @(posedge clk) begin
    if (rst) badvaddr_q <= 32'd0;
    else     badvaddr_q <= badvaddr_d;
  end

  assign badvaddr_rd = badvaddr_q;
`else
  logic [31:0] unused_badvaddr;
  assign unused_badvaddr = exc_badvaddr_i;
  assign badvaddr_rd     = 32'd0;
`endif

  always_comb begin
    case (raddr_i)
      ADDR_BADVADDR: rdata_o = badvaddr_rd;
      ADDR_COUNT:    rdata_o = tif.count;
      ADDR_COMPARE:  rdata_o = tif.compare;
      ADDR_STATUS:   rdata_o = status_q;
      ADDR_CAUSE:    rdata_o = cause_q;
      ADDR_EPC:      rdata_o = epc_q;
      ADDR_PRID:     rdata_o = PRID_VAL;
      ADDR_CONFIG:   rdata_o = CONFIG_VAL;
      default:       rdata_o = 32'd0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign count_o     = tif.count;
  assign compare_o   = tif.compare;
  assign timer_int_o = tif.timer_int;
  assign int_req_o   = status_q[ST_IE] & ~status_q[ST_EXL]
                     & (|(cause_q[CA_IP_HI:CA_IP_LO] & status_q[ST_IM_HI:ST_IM_LO]));

endmodule

// File: tb/tb_cp0_exc.sv
// tb/tb_cp0_exc.sv - self-checking bench for cp0_exc (COUNT_DIV 1 and 2 instances)
module tb_cp0_exc;

  logic        clk, rst;
  logic        we, exc_valid, exc_bd, eret;
  logic [4:0]  waddr, raddr, exc_code, int_v;
  logic [31:0] wdata, exc_pc, exc_badvaddr;
  logic [31:0] rdata, status, cause, epc, count, compare;
  logic        timer_int, int_req;
  logic [31:0] rdata2, status2, cause2, epc2, count2, compare2;
  logic        timer_int2, int_req2;

  int pass_cnt = 0;
  int total_cnt = 0;

  cp0_exc #(.NUM_HW_INT(5), .COUNT_DIV(1), .PRID_VAL(32'h0001_0101)) dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata), .int_i(int_v), .exc_valid_i(exc_valid),
    .exc_code_i(exc_code), .exc_pc_i(exc_pc), .exc_bd_i(exc_bd),
    .exc_badvaddr_i(exc_badvaddr), .eret_i(eret), .status_o(status),
    .cause_o(cause), .epc_o(epc), .count_o(count), .compare_o(compare),
    .timer_int_o(timer_int), .int_req_o(int_req));

  cp0_exc #(.NUM_HW_INT(5), .COUNT_DIV(2), .PRID_VAL(32'h0001_0101)) dut2 (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata2), .int_i(int_v), .exc_valid_i(exc_valid),
    .exc_code_i(exc_code), .exc_pc_i(exc_pc), .exc_bd_i(exc_bd),
    .exc_badvaddr_i(exc_badvaddr), .eret_i(eret), .status_o(status2),
    .cause_o(cause2), .epc_o(epc2), .count_o(count2), .compare_o(compare2),
    .timer_int_o(timer_int2), .int_req_o(int_req2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; exc_valid = 0; exc_code = 0;
    exc_pc = 0; exc_bd = 0; exc_badvaddr = 0; eret = 0;
  endtask

  task automatic do_reset();
    idle();
    int_v = 0;
    rst = 1;
    step();
    rst = 0;
  endtask

  logic [4:0]  codes[5];
  logic [31:0] bva_exp;
  logic [31:0] m_status, m_epc, m_sw, m_bva, e_cause;
  logic [4:0]  m_code, m_hw;
  logic        m_bd, e_req;
  int          n, cyc;

  initial begin
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd12};
    vecs[0] = '{"status_wmask",   5'd12, 32'hFFFF_FFFF, 5'd12, 32'hF000_FF03};
    vecs[1] = '{"cause_wmask",    5'd13, 32'hFFFF_FFFF, 5'd13, 32'h00C0_0300};
    vecs[2] = '{"epc_rw",         5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
    vecs[3] = '{"compare_rw",     5'd11, 32'h0000_0100, 5'd11, 32'h0000_0100};
    vecs[4] = '{"count_rw",       5'd9,  32'hABCD_0000, 5'd9,  32'hABCD_0000};
    vecs[5] = '{"prid_ro",        5'd15, 32'hFFFF_FFFF, 5'd15, 32'h0001_0101};
    vecs[6] = '{"config_ro",      5'd16, 32'h0000_0000, 5'd16, 32'h0000_8000};
    vecs[7] = '{"badvaddr_ro",    5'd8,  32'hDEAD_BEEF, 5'd8,  32'h0000_0000};
    vecs[8] = '{"unmapped_read",  5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
    vecs[9] = '{"cause_clear",    5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
`ifdef CP0_BADVADDR_EN
    bva_exp = 32'h0000_0003;
`else
    bva_exp = 32'h0000_0000;
`endif
    raddr = 5'd15;
    do_reset();

    chk("rst_status", status, 32'h1000_0000);
    chk("rst_cause", cause, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_compare", compare, 32'h0);
    chk("rst_timer", timer_int, 1'b0);
    chk("rst_prid", rdata, 32'h0001_0101);
    for (int i = 0; i < 5; i++) begin
      chk("count_div1", count, i);
      chk("count_div2", count2, i / 2);
      if (i < 4) step();
    end

    for (int i = 0; i < 10; i++) begin
      we = 1; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      step();
      idle();
      raddr = vecs[i].raddr;
      #1;
      chk(vecs[i].name, rdata, vecs[i].exp);
    end

    // Timer match, sticky interrupt and acknowledge
    do_reset();
    we = 1; waddr = 5'd11; wdata = 32'd5; step(); idle();
    n = 0;
    while (count != 32'd5 && n < 20) begin step(); n++; end
    chk("count_reaches_5", count, 32'd5);
    chk("timer_low_in_match", timer_int, 1'b0);
    step(); chk("timer_set_after_match", timer_int, 1'b1);
    step(); chk("cause_ip7", cause[15], 1'b1);
    chk("timer_sticky", timer_int, 1'b1);
    we = 1; waddr = 5'd11; wdata = 32'd0; step(); idle();
    chk("timer_ack", timer_int, 1'b0);

    // Compare write in the match cycle wins
    we = 1; waddr = 5'd11; wdata = 32'd50; step();
    waddr = 5'd9; wdata = 32'd48; step(); idle();
    step(); step();
    chk("count_at_50", count, 32'd50);
    we = 1; waddr = 5'd11; wdata = 32'd200; step(); idle();
    chk("compare_write_wins", timer_int, 1'b0);
    chk("compare_200", compare, 32'd200);

    // Hardware interrupt and exception entry
    we = 1; waddr = 5'd12; wdata = 32'h1000_FF01; int_v = 5'b00001; step(); idle();
    chk("cause_ip2", cause[10], 1'b1);
    chk("int_req_on", int_req, 1'b1);
    exc_valid = 1; exc_code = 5'd0; exc_pc = 32'h0000_1000; step(); idle();
    chk("exl_set", status[1], 1'b1);
    chk("int_req_masked", int_req, 1'b0);
    chk("epc_first", epc, 32'h0000_1000);
    eret = 1; step(); idle();
    chk("eret_exl_clr", status[1], 1'b0);
    chk("eret_epc_keep", epc, 32'h0000_1000);

    exc_valid = 1; exc_code = 5'd12; exc_pc = 32'hBFC0_0100; exc_bd = 1; step(); idle();
    chk("epc_bd", epc, 32'hBFC0_00FC);
    chk("cause_bd", cause[31], 1'b1);
    chk("exccode_ov", cause[6:2], 5'd12);
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h8000_0000; step(); idle();
    chk("nested_epc_keep", epc, 32'hBFC0_00FC);
    chk("nested_bd_keep", cause[31], 1'b1);
    chk("nested_exccode", cause[6:2], 5'd8);

    // Exception vs eret vs mtc0 in the same cycle
    eret = 1; step(); idle();
    exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h0000_2000; eret = 1;
    we = 1; waddr = 5'd12; wdata = 32'h0; raddr = 5'd12;
    #1;
    chk("read_old_status", rdata, 32'h1000_FF01);
    step(); idle();
    chk("prio_status", status, 32'h1000_FF03);
    chk("prio_epc", epc, 32'h0000_2000);

    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h0000_3000; exc_badvaddr = 32'h0000_0003;
    raddr = 5'd8; step(); idle();
    chk("badvaddr_read", rdata, bva_exp);
    chk("adel_epc_keep", epc, 32'h0000_2000);

    // Count wrap, both dividers
    we = 1; waddr = 5'd9; wdata = 32'hFFFF_FFFF; step(); idle();
    chk("wrap_load", count, 32'hFFFF_FFFF);
    chk("wrap_load_div2", count2, 32'hFFFF_FFFF);
    step();
    chk("wrap_zero", count, 32'h0);
    chk("wrap_hold_div2", count2, 32'hFFFF_FFFF);
    step();
    chk("wrap_zero_div2", count2, 32'h0);

    // Reset mid-operation with EXL and a pending timer
    we = 1; waddr = 5'd11; wdata = count + 32'd3; step(); idle();
    n = 0;
    while (!timer_int && n < 10) begin step(); n++; end
    chk("timer_pending", timer_int, 1'b1);
    rst = 1; exc_valid = 1; exc_code = 5'd4; exc_badvaddr = 32'hFFFF_FFFF; eret = 1;
    we = 1; waddr = 5'd12; wdata = 32'hFFFF_FFFF; int_v = 5'h1F; raddr = 5'd8;
    step();
    rst = 0; idle(); int_v = 0;
    chk("midrst_status", status, 32'h1000_0000);
    chk("midrst_cause", cause, 32'h0);
    chk("midrst_epc", epc, 32'h0);
    chk("midrst_count", count, 32'h0);
    chk("midrst_compare", compare, 32'h0);
    chk("midrst_timer", timer_int, 1'b0);
    chk("midrst_badvaddr", rdata, 32'h0);

    // Randomized traffic against a rule-level model
    do_reset();
    m_status = 32'h1000_0000; m_epc = 0; m_sw = 0; m_bva = 0;
    m_code = 0; m_hw = 0; m_bd = 0; cyc = 0;
    raddr = 5'd8;
    for (int i = 0; i < 300; i++) begin
      idle();
      int_v = 5'($urandom);
      exc_valid = ($urandom_range(7) == 0);
      eret = ($urandom_range(5) == 0);
      we = ($urandom_range(2) == 0);
      waddr = 5'd12 + 5'($urandom_range(2));
      wdata = $urandom;
      exc_code = codes[$urandom_range(4)];
      exc_pc = $urandom & 32'hFFFF_FFFC;
      exc_bd = 1'($urandom);
      exc_badvaddr = $urandom;
      step();
      cyc++;
      if (exc_valid) begin
        if (!m_status[1]) begin
          m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
          m_bd = exc_bd;
        end
        m_code = exc_code;
        m_status[1] = 1'b1;
`ifdef CP0_BADVADDR_EN
        if (exc_code == 5'd4 || exc_code == 5'd5) m_bva = exc_badvaddr;
`endif
      end else if (eret) begin
        m_status[1] = 1'b0;
      end else if (we) begin
        if (waddr == 5'd12) m_status = wdata & 32'hF000_FF03;
        if (waddr == 5'd13) m_sw = wdata & 32'h00C0_0300;
        if (waddr == 5'd14) m_epc = wdata;
      end
      m_hw = int_v;
      e_cause = (32'(m_bd) << 31) | m_sw | (32'(m_hw) << 10) | (32'(m_code) << 2);
      e_req = m_status[0] & ~m_status[1] & (|(e_cause[15:8] & m_status[15:8]));
      chk("rnd_status", status, m_status);
      chk("rnd_cause", cause, e_cause);
      chk("rnd_epc", epc, m_epc);
      chk("rnd_int_req", int_req, e_req);
      chk("rnd_count", count, cyc);
      chk("rnd_count_div2", count2, cyc / 2);
      chk("rnd_badvaddr", rdata, m_bva);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cp0_exc.md
CP0_EXC -- requirements
Module: cp0_exc

Interface
REQ-001 SHALL have parameter NUM_HW_INT, default 5, number of hardware interrupt lines (1..5).
REQ-002 SHALL have parameter COUNT_DIV, default 1, Count increment period in cycles (1 or 2).
REQ-003 SHALL have parameter PRID_VAL, default 32'h0001_0101, PRId reset/read value.
REQ-004 SHALL have ports: clk input 1, rising-edge clock; rst input 1, reset, synchronous, active-high.
REQ-005 SHALL have ports: we_i input 1 (mtc0 write enable); waddr_i input 5; wdata_i input 32; raddr_i input 5; rdata_o output 32 (mfc0 data).
REQ-006 SHALL have ports: int_i input NUM_HW_INT (level hardware interrupts).
REQ-007 SHALL have ports: exc_valid_i input 1; exc_code_i input 5; exc_pc_i input 32; exc_bd_i input 1 (in delay slot); exc_badvaddr_i input 32; eret_i input 1.
REQ-008 SHALL have ports: status_o, cause_o, epc_o, count_o, compare_o outputs 32 (registered); timer_int_o output 1; int_req_o output 1.

Function
REQ-009 Count SHALL increment by 1 every COUNT_DIV cycles, wrapping 0xFFFF_FFFF->0. An mtc0 write to Count loads wdata_i and restarts the divider.
REQ-010 timer_int_o SHALL set on the cycle after Count==Compare with Compare!=0. It SHALL stay set until Compare is written. A Compare write in the match cycle SHALL win, leaving timer_int_o clear.
REQ-011 Cause.IP[2+k] SHALL register int_i[k] every cycle for k<NUM_HW_INT. Unused IP[6:2] bits SHALL read 0. Cause.IP[7] SHALL register timer_int_o.
REQ-012 Writable bits: Status CU[31:28], IM[15:8], EXL[1], IE[0] (others read 0); Cause IP[9:8], IV[23], WP[22]; EPC, Count and Compare all bits. PRId and Config SHALL be read-only.
REQ-013 int_req_o SHALL be combinational: Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM).
REQ-014 Exception entry (exc_valid_i=1) with Status.EXL=0: EPC<=exc_bd_i ? exc_pc_i-4 : exc_pc_i; Cause.BD<=exc_bd_i.
REQ-015 Exception entry with Status.EXL=1 (nested): EPC and Cause.BD unchanged.
REQ-016 Every exception entry: Cause.ExcCode[6:2]<=exc_code_i; Status.EXL<=1.
REQ-017 eret_i=1 SHALL clear Status.EXL next cycle; EPC unchanged.
REQ-018 Same-cycle priority: exc_valid_i > eret_i > mtc0 write to Status/Cause/EPC. The losing write SHALL be discarded. Count/Compare writes are unaffected.
REQ-019 rdata_o SHALL be combinational from current register state for addresses Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16. Any other address SHALL read 0. A same-cycle read of a written register SHALL return the old value.

Reset
REQ-020 On rst: Count 0, Compare 0, Status 32'h1000_0000, Cause 0, EPC 0, timer_int_o 0, divider 0, Config 32'h0000_8000; PRId reads PRID_VAL.
REQ-021 rst SHALL override exc_valid_i, eret_i and we_i in the same cycle.
REQ-022 rst asserted mid-operation (EXL=1, timer pending) SHALL restore all REQ-020 values in one cycle.

Configuration
REQ-023 With CP0_BADVADDR_EN defined: BadVAddr register (address 8, read-only to mtc0, reset 0) SHALL load exc_badvaddr_i on entry when exc_code_i is AdEL(4) or AdES(5), regardless of EXL.
REQ-024 Without CP0_BADVADDR_EN: no BadVAddr storage; address 8 reads 0; exc_badvaddr_i is ignored.

Structure
REQ-025 Shared package cp0_pkg SHALL hold register address constants, ExcCode values (Int 0, AdEL 4, AdES 5, Sys 8, Ov 12) and Status/Cause field bit positions.
REQ-026 Count/Compare/divider/timer_int SHALL live in sub-module cp0_timer; cp0_exc instantiates it once.

Verification
REQ-027 Write Compare=5 after reset, COUNT_DIV=1 -> timer_int_o rises the cycle after Count==5, Cause[15]=1; writing Compare=0 clears it next cycle.
REQ-028 Status=32'h1000_FF01, int_i[0]=1 -> Cause[10]=1 next cycle, int_req_o=1; exc_valid_i with code 0 -> EXL=1, int_req_o=0.
REQ-029 exc_valid_i, exc_pc_i=32'hBFC0_0100, exc_bd_i=1, EXL=0 -> EPC=32'hBFC0_00FC, Cause[31]=1. A second exception at 32'h8000_0000 -> EPC unchanged, ExcCode updated.
REQ-030 Same cycle: exc_valid_i=1, eret_i=1, mtc0 Status=0 -> EXL=1 and the mtc0 Status write is discarded.
REQ-031 COUNT_DIV=2: Count reads 0,0,1,1,2 over five cycles after reset. Count=32'hFFFF_FFFF wraps to 0.
REQ-032 CP0_BADVADDR_EN defined, exception code 4, badvaddr 32'h0000_0003 -> mfc0 address 8 returns 32'h0000_0003. Undefined -> returns 0.
